// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg -- shared types and constants for the BCD counter slice.
//   bcd_t            : one BCD digit (4 bits, legal values 0..9)
//   BCD_MAX/BCD_MIN  : digit limits
//   state_t          : control FSM states (STOP, RUN, LACK)
//   bcd_legal()      : true when a 4-bit code is a legal BCD digit
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_LACK = 2'd2
    } state_t;

    function automatic logic bcd_legal(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_prescaler.sv
// ---------------------------------------------------------------------------
// bcd_prescaler -- divides enabled clock cycles down to count steps.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (counter -> 0)
//   run  : count this cycle; low freezes the counter at its current value
//   clr  : synchronous clear to 0 (load restarts the step interval)
//   tick : high in the run cycle where the counter sits at PRESCALE-1
// ---------------------------------------------------------------------------
module bcd_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] cnt;

    // With PRESCALE=1, LAST is 0 and the counter never leaves 0, so every
    // run cycle ticks.
    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 8'd0;
        end else if (run) begin
            cnt <= tick ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bcd_cnt.sv
// ---------------------------------------------------------------------------
// bcd_cnt -- prescaled up/down single-digit BCD counter with parallel load.
//   clk, rst            : clock (rising edge) and synchronous active-high reset
//   en                  : count enable (low freezes prescaler and digit)
//   up                  : 1 = increment, 0 = decrement
//   load_valid/ready    : load handshake
//   load_data[3:0]      : load value (bit3 = weight 8)
//   a0..a3              : registered digit, a0 = weight 8 ... a3 = weight 1
//   tc                  : terminal-count pulse (tick taken at 9 up / 0 down)
//   err                 : one-cycle pulse after an accepted load of 10..15
// Build option: define BCD_CNT_SATURATE_EN to hold at the limits instead of
// wrapping 9->0 / 0->9.
//
// Load handshake: a load transfers in any cycle where load_valid and
// load_ready are both 1 at the rising edge; load_valid may be held without
// load_ready, and load_ready drops only for the single LACK cycle that
// follows each accepted load.
// ---------------------------------------------------------------------------
module bcd_cnt
    import bcd_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       tc,
    output logic       err
);

    state_t state;
    state_t state_nxt;
    bcd_t   digit;
    logic   err_q;
    logic   run;
    logic   tick;
    logic   load_acc;
    logic   load_ok;
    logic   step;
    logic   at_limit;

    function automatic bcd_t step_digit(input bcd_t d, input logic dir);
`ifdef BCD_CNT_SATURATE_EN
        if (dir) return (d >= BCD_MAX) ? BCD_MAX : d + 4'd1;
        else     return (d == BCD_MIN) ? BCD_MIN : d - 4'd1;
`else
        if (dir) return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
        else     return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
`endif
    endfunction

    assign load_ready = (state != ST_LACK);
    assign load_acc   = load_valid && load_ready;
    assign load_ok    = bcd_legal(load_data);

    // The prescaler only advances in RUN and only while en is still high,
    // so dropping en freezes it in the same cycle.
    assign run = en && (state == ST_RUN);

    // A load in the tick cycle wins: the step and its tc are suppressed.
    assign step     = tick && !load_acc;
    assign at_limit = up ? (digit == BCD_MAX) : (digit == BCD_MIN);
    assign tc       = step && at_limit && !rst;

    bcd_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run),
        .clr (load_acc),
        .tick(tick)
    );

    always_comb begin
        state_nxt = en ? ST_RUN : ST_STOP;
        if (load_acc) begin
            state_nxt = ST_LACK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
            digit <= BCD_MIN;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= load_acc && !load_ok;
            if (load_acc) begin
                if (load_ok) begin
                    digit <= load_data;
                end
            end else if (step) begin
                digit <= step_digit(digit, up);
            end
        end
    end

    assign err = err_q;
    assign a0  = digit[3];
    assign a1  = digit[2];
    assign a2  = digit[1];
    assign a3  = digit[0];

endmodule

// File: tb/tb_bcd_cnt.sv
// ---------------------------------------------------------------------------
// tb_bcd_cnt -- directed bench for bcd_cnt. Two instances (PRESCALE=1 and
// PRESCALE=4) share all inputs; sel4 picks which one the monitor checks.
// Each expected entry packs {digit[3:0], tc, err, load_ready}.
// ---------------------------------------------------------------------------
module tb_bcd_cnt;

`ifdef BCD_CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load_valid;
    logic [3:0] load_data;

    logic ready1, b0_1, b1_1, b2_1, b3_1, tc1, err1;
    logic ready4, b0_4, b1_4, b2_4, b3_4, tc4, err4;

    logic [6:0] exp_q[$];
    logic       chk = 1'b0;
    logic       sel4 = 1'b0;
    string      tname = "reset";
    int         n_tests = 0;
    int         n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    bcd_cnt #(.PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up),
        .load_valid(load_valid), .load_data(load_data), .load_ready(ready1),
        .a0(b0_1), .a1(b1_1), .a2(b2_1), .a3(b3_1), .tc(tc1), .err(err1)
    );

    bcd_cnt #(.PRESCALE(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .up(up),
        .load_valid(load_valid), .load_data(load_data), .load_ready(ready4),
        .a0(b0_4), .a1(b1_4), .a2(b2_4), .a3(b3_4), .tc(tc4), .err(err4)
    );

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [6:0] act;
        logic [6:0] exp_v;
        if (chk) begin
            act = sel4 ? {b0_4, b1_4, b2_4, b3_4, tc4, err4, ready4}
                       : {b0_1, b1_1, b2_1, b3_1, tc1, err1, ready1};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: no expected entry, got digit=%0d tc=%b err=%b ready=%b",
                         tname, act[6:3], act[2], act[1], act[0]);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got digit=%0d tc=%b err=%b ready=%b, want digit=%0d tc=%b err=%b ready=%b",
                             tname, $time, act[6:3], act[2], act[1], act[0],
                             exp_v[6:3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Holds the current inputs for one cycle; when c is set, the outputs
    // during this cycle must match the given expectation.
    task automatic cyc(input logic c, input logic [3:0] d, input logic t,
                       input logic e, input logic r);
        chk = c;
        if (c) exp_q.push_back({d, t, e, r});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load_valid = 1'b0; load_data = 4'd0;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] d;
        logic       t;

        rst = 1'b1; en = 1'b0; up = 1'b1; load_valid = 1'b0; load_data = 4'd0;
        @(posedge clk);
        #1;

        // Reset state and up-count with PRESCALE=1.
        sel4 = 1'b0;
        do_reset();
        en = 1'b1; up = 1'b1;
        tname = "reset_state";
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tname = "up_p1";
        for (int k = 1; k <= 12; k++) begin
            if (SAT) d = (k - 1 > 9) ? 4'd9 : 4'(k - 1);
            else     d = 4'((k - 1) % 10);
            t = (k == 10) || (SAT && k > 10);
            cyc(1'b1, d, t, 1'b0, 1'b1);
        end

        // Load 7 then count down with PRESCALE=4.
        sel4 = 1'b1;
        do_reset();
        tname = "load7_accept";
        en = 1'b1; up = 1'b0; load_valid = 1'b1; load_data = 4'd7;
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        tname = "load7_lack";
        cyc(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        tname = "down_p4";
        for (int b = 0; b <= 8; b++) begin
            for (int j = 0; j < 4; j++) begin
                if (b <= 7) d = 4'(7 - b);
                else        d = SAT ? 4'd0 : 4'd9;
                t = (j == 3) && (d == 4'd0);
                cyc(1'b1, d, t, 1'b0, 1'b1);
            end
        end

        // Illegal load of 12 while holding 5.
        do_reset();
        en = 1'b0; load_valid = 1'b1; load_data = 4'd5;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        tname = "load5_lack";
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        tname = "bad_load_accept";
        load_valid = 1'b1; load_data = 4'd12;
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        tname = "bad_load_err";
        cyc(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        tname = "bad_load_after";
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);

        // Load 3 in the tick cycle with digit 9 counting up.
        en = 1'b1; up = 1'b1; load_valid = 1'b1; load_data = 4'd9;
        cyc(1'b0, 4'd5, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        tname = "load9_lack";
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        tname = "hold9";
        for (int j = 0; j < 3; j++) cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        tname = "load_vs_tick";
        load_valid = 1'b1; load_data = 4'd3;
        cyc(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        tname = "load3_lack";
        cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tname = "restart_p4";
        for (int j = 0; j < 4; j++) cyc(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);

        // Reset mid-count: digit 6, prescaler 2.
        load_valid = 1'b1; load_data = 4'd6;
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        cyc(1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        tname = "pre_rst";
        cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tname = "rst_cycle";
        cyc(1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; en = 1'b0;
        tname = "after_rst";
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);

        // Reset beats a simultaneous load.
        rst = 1'b1; en = 1'b1; load_valid = 1'b1; load_data = 4'd8;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0; en = 1'b0; load_valid = 1'b0;
        tname = "rst_over_load";
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1);

        // Freeze with prescaler at 2, then resume.
        en = 1'b1; up = 1'b1; load_valid = 1'b1; load_data = 4'd4;
        cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b0;
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 4'd4, 1'b0, 1'b0, 1'b1);
        tname = "freeze";
        en = 1'b0;
        for (int j = 0; j < 5; j++) cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
        en = 1'b1;
        tname = "resume";
        cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd4, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);

        chk = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
